throw_arbiter: RTL and testbench
================================

Name: throw_arbiter

Overview:
- Owns the single projectile trajectory engine and grants it to the dog (local) or cat (remote) requester.
- Sits between the turn FSMs (throw-enable level requests plus force values) and the trajectory engine.
- Enforces turn ownership, launches the engine, and supervises the flight with a timeout.
- Routes done/hit pulses back to the owning side and the health bars.

Parameters:
FORCE_W, 10, width of throw force values
TIMEOUT_CYC, 130_000_000, max flight cycles before abort (2 s @ 65 MHz)
COOLDOWN_CYC, 65_000, idle gap after each throw (1 ms @ 65 MHz)

Ports:
clk  in  1  system clock (65 MHz)
rst_n  in  1  reset, asynchronous, active-low
dog_turn  in  1  dog side owns current turn (level)
cat_turn  in  1  cat side owns current turn (level)
req_dog  in  1  dog throw request (level)
req_cat  in  1  cat throw request (level)
force_dog  in  FORCE_W  dog throw force
force_cat  in  FORCE_W  cat throw force
eng_done  in  1  engine flight finished (1-cycle pulse)
eng_hit  in  1  qualifies eng_done: projectile hit opponent
gnt_dog  out  1  engine granted to dog
gnt_cat  out  1  engine granted to cat
eng_start  out  1  1-cycle launch pulse
eng_force  out  FORCE_W  latched force of owner
eng_dir  out  1  0 = dog throws right, 1 = cat throws left
eng_abort  out  1  1-cycle abort pulse on timeout
done_dog  out  1  1-cycle turn-done pulse to dog side
done_cat  out  1  1-cycle turn-done pulse to cat side
hit_cat  out  1  1-cycle pulse: dog hit cat
hit_dog  out  1  1-cycle pulse: cat hit dog
busy  out  1  high in every state except IDLE
timeout_flag  out  1  sticky: any flight timed out

Behaviour:
- States: IDLE, LAUNCH, FLIGHT, COOLDOWN. All outputs are registered.
- Reset values: state IDLE; every output 0; last_owner = cat; both armed flags = 1; counters = 0.
- Eligibility: elig_dog = req_dog & dog_turn & armed_dog. elig_cat is the same with cat signals.
- Armed flags: armed_x is cleared on grant to x. It sets again in any cycle where req_x = 0. This prevents a held request from re-throwing.
- IDLE, neither eligible: stay in IDLE.
- IDLE, exactly one eligible: latch owner, latch that side's force into eng_force, set eng_dir, go to LAUNCH.
- IDLE, both eligible: round-robin; the side opposite last_owner wins, so the dog wins first after reset.
- Latency: eligibility sampled at edge N. From edge N+1: state LAUNCH, gnt_owner = 1, eng_start = 1 for exactly one cycle, eng_force/eng_dir valid.
- LAUNCH → FLIGHT unconditionally. gnt_owner stays high and eng_force stays stable through FLIGHT.
- FLIGHT, flight counter: increments each cycle from 0.
- FLIGHT, on eng_done:
  - done_owner pulses 1 cycle.
  - If eng_hit: hit_cat (dog owner) or hit_dog (cat owner) pulses in the same cycle.
  - Update last_owner, go to COOLDOWN.
- FLIGHT, timeout: counter reaches TIMEOUT_CYC-1 without eng_done. Then eng_abort and done_owner pulse, no hit pulse, timeout_flag set, go to COOLDOWN.
- FLIGHT, eng_done on the timeout cycle: done wins and there is no abort.
- FLIGHT, owner's turn signal drops: ignored; the flight completes normally.
- COOLDOWN: gnt_* low. Counts COOLDOWN_CYC cycles with requests ignored, then goes to IDLE.
- eng_done/eng_hit outside FLIGHT: ignored, no output pulse.
- gnt_dog and gnt_cat are never high together. At most one done_* and one hit_* pulse per throw.
- rst_n low mid-flight: immediate return to reset values with no pulses. timeout_flag clears only on reset.

Optional Feature:
- Macro: THROW_ARB_STATS_EN.
- Defined: adds outputs throws_dog[7:0], throws_cat[7:0], timeouts[7:0].
  - throws_x increments at each LAUNCH of x; timeouts increments at each abort.
  - All three saturate at 255 and reset to 0.
- Undefined: the ports exist but are tied to 0, and no counter logic is present.

Test Plan:
- Reset release, dog_turn = 1, req_dog = 1, force_dog = 300 → next cycle gnt_dog = 1, eng_start = 1 (1 cycle), eng_force = 300, eng_dir = 0. Then eng_done + eng_hit → done_dog = 1 and hit_cat = 1 in the same cycle. Then COOLDOWN_CYC cycles with busy = 1, then IDLE.
- req_dog held high through the whole throw and cooldown → no second grant. Drop req_dog for 1 cycle and raise it again → new grant.
- req_cat = 1 with cat_turn = 0 → no grant, busy stays 0.
- Both eligible at the same cycle after reset → dog granted. Repeat after done → cat granted (round-robin).
- Override TIMEOUT_CYC = 100, withhold eng_done → eng_abort and done_cat pulse at flight cycle 100, hit_dog = 0, timeout_flag = 1. eng_done coincident with the timeout cycle → no abort.
- Assert rst_n = 0 during FLIGHT → all outputs 0 immediately. Late eng_done after reset → no done/hit pulse.

Source files
------------

// File: rtl/throw_arbiter.sv
// throw_arbiter: grants the single trajectory engine to the dog or cat side,
// launches the throw, supervises the flight with a timeout, applies a
// cooldown gap and routes done/hit pulses back to the owning side.
// Optional statistics counters are enabled by defining THROW_ARB_STATS_EN.
module throw_arbiter #(
    parameter int unsigned FORCE_W      = 10,
    parameter int unsigned TIMEOUT_CYC  = 130_000_000,
    parameter int unsigned COOLDOWN_CYC = 65_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dog_turn,
    input  logic               cat_turn,
    input  logic               req_dog,
    input  logic               req_cat,
    input  logic [FORCE_W-1:0] force_dog,
    input  logic [FORCE_W-1:0] force_cat,
    input  logic               eng_done,
    input  logic               eng_hit,
    output logic               gnt_dog,
    output logic               gnt_cat,
    output logic               eng_start,
    output logic [FORCE_W-1:0] eng_force,
    output logic               eng_dir,
    output logic               eng_abort,
    output logic               done_dog,
    output logic               done_cat,
    output logic               hit_cat,
    output logic               hit_dog,
    output logic               busy,
    output logic               timeout_flag,
    output logic [7:0]         throws_dog,
    output logic [7:0]         throws_cat,
    output logic [7:0]         timeouts
);

    localparam int unsigned TO_W = (TIMEOUT_CYC  > 1) ? $clog2(TIMEOUT_CYC)  : 1;
    localparam int unsigned CD_W = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        FLIGHT,
        COOLDOWN
    } state_t;

    state_t          state;
    logic            owner_cat;   // 0 = dog owns the engine, 1 = cat
    logic            last_cat;    // owner of the most recently finished throw
    logic            armed_dog;
    logic            armed_cat;
    logic [TO_W-1:0] flight_cnt;
    logic [CD_W-1:0] cool_cnt;

    logic elig_dog;
    logic elig_cat;
    logic pick_cat;
    logic grant;
    logic flight_to;

    // Eligibility and round-robin winner selection for the IDLE decision
    always_comb begin
        elig_dog  = req_dog & dog_turn & armed_dog;
        elig_cat  = req_cat & cat_turn & armed_cat;
        // on a tie the side opposite the last owner wins
        pick_cat  = elig_cat & (~elig_dog | ~last_cat);
        grant     = (state == IDLE) & (elig_dog | elig_cat);
        flight_to = (flight_cnt == TO_LAST);
    end

    // Arbitration FSM with registered outputs and re-arm tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner_cat    <= 1'b0;
            last_cat     <= 1'b1;
            armed_dog    <= 1'b1;
            armed_cat    <= 1'b1;
            flight_cnt   <= '0;
            cool_cnt     <= '0;
            gnt_dog      <= 1'b0;
            gnt_cat      <= 1'b0;
            eng_start    <= 1'b0;
            eng_force    <= '0;
            eng_dir      <= 1'b0;
            eng_abort    <= 1'b0;
            done_dog     <= 1'b0;
            done_cat     <= 1'b0;
            hit_cat      <= 1'b0;
            hit_dog      <= 1'b0;
            busy         <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            eng_abort <= 1'b0;
            done_dog  <= 1'b0;
            done_cat  <= 1'b0;
            hit_cat   <= 1'b0;
            hit_dog   <= 1'b0;

            // a held request stays disarmed until it is released for a cycle
            if (grant && !pick_cat) armed_dog <= 1'b0;
            else if (!req_dog)      armed_dog <= 1'b1;
            if (grant && pick_cat)  armed_cat <= 1'b0;
            else if (!req_cat)      armed_cat <= 1'b1;

            case (state)
                IDLE: begin
                    if (grant) begin
                        state     <= LAUNCH;
                        owner_cat <= pick_cat;
                        gnt_dog   <= ~pick_cat;
                        gnt_cat   <= pick_cat;
                        eng_start <= 1'b1;
                        eng_force <= pick_cat ? force_cat : force_dog;
                        eng_dir   <= pick_cat;
                        busy      <= 1'b1;
                    end
                end
                LAUNCH: begin
                    state      <= FLIGHT;
                    flight_cnt <= '0;
                end
                FLIGHT: begin
                    if (eng_done || flight_to) begin
                        state    <= COOLDOWN;
                        cool_cnt <= '0;
                        gnt_dog  <= 1'b0;
                        gnt_cat  <= 1'b0;
                        last_cat <= owner_cat;
                        done_dog <= ~owner_cat;
                        done_cat <= owner_cat;
                        if (eng_done) begin
                            hit_cat <= eng_hit & ~owner_cat;
                            hit_dog <= eng_hit & owner_cat;
                        end else begin
                            eng_abort    <= 1'b1;
                            timeout_flag <= 1'b1;
                        end
                    end else begin
                        flight_cnt <= flight_cnt + TO_W'(1);
                    end
                end
                COOLDOWN: begin
                    if (cool_cnt == CD_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cool_cnt <= cool_cnt + CD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef THROW_ARB_STATS_EN
    logic abort_now;
    assign abort_now = (state == FLIGHT) & ~eng_done & flight_to;

    // Saturating launch and timeout statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            throws_dog <= '0;
            throws_cat <= '0;
            timeouts   <= '0;
        end else begin
            if (grant && !pick_cat && throws_dog != 8'hFF) throws_dog <= throws_dog + 8'd1;
            if (grant && pick_cat && throws_cat != 8'hFF)  throws_cat <= throws_cat + 8'd1;
            if (abort_now && timeouts != 8'hFF)            timeouts   <= timeouts + 8'd1;
        end
    end
`else
    assign throws_dog = '0;
    assign throws_cat = '0;
    assign timeouts   = '0;
`endif

endmodule

// File: tb/tb_throw_arbiter.sv
// tb_throw_arbiter: directed and randomized checks of throw_arbiter against
// a timeline-based reference model (grant / end / idle cycle numbers).
module tb_throw_arbiter;

    localparam int unsigned FW = 10;
    localparam int unsigned TO = 100;
    localparam int unsigned CD = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dog_turn = 1'b0, cat_turn = 1'b0;
    logic          req_dog = 1'b0, req_cat = 1'b0;
    logic [FW-1:0] force_dog = '0, force_cat = '0;
    logic          eng_done = 1'b0, eng_hit = 1'b0;
    logic          gnt_dog, gnt_cat, eng_start, eng_dir, eng_abort;
    logic [FW-1:0] eng_force;
    logic          done_dog, done_cat, hit_cat, hit_dog, busy, timeout_flag;
    logic [7:0]    throws_dog, throws_cat, timeouts;

    throw_arbiter #(.FORCE_W(FW), .TIMEOUT_CYC(TO), .COOLDOWN_CYC(CD)) dut (
        .clk(clk), .rst_n(rst_n), .dog_turn(dog_turn), .cat_turn(cat_turn),
        .req_dog(req_dog), .req_cat(req_cat), .force_dog(force_dog), .force_cat(force_cat),
        .eng_done(eng_done), .eng_hit(eng_hit), .gnt_dog(gnt_dog), .gnt_cat(gnt_cat),
        .eng_start(eng_start), .eng_force(eng_force), .eng_dir(eng_dir), .eng_abort(eng_abort),
        .done_dog(done_dog), .done_cat(done_cat), .hit_cat(hit_cat), .hit_dog(hit_dog),
        .busy(busy), .timeout_flag(timeout_flag), .throws_dog(throws_dog),
        .throws_cat(throws_cat), .timeouts(timeouts)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: a throw is a timeline ----------------
    // g_cyc: cycle showing the launch pulse; end_cyc: cycle showing done/abort;
    // the engine is free again from end_cyc + CD on.
    longint  cyc = 0, g_cyc = 0, end_cyc = 0, prev;
    bit      active = 0, ended = 0, m_own = 0, m_last = 1, m_hit = 0, m_abort = 0;
    bit      m_armd = 1, m_armc = 1, m_tflag = 0, m_dir = 0;
    bit      ed, ec, own, grant, idle_prev;
    logic [FW-1:0] m_force = '0;
    int      m_tdog = 0, m_tcat = 0, m_tos = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active = 0; ended = 0; m_last = 1; m_armd = 1; m_armc = 1;
            m_tflag = 0; m_force = '0; m_dir = 0; m_own = 0;
            m_tdog = 0; m_tcat = 0; m_tos = 0;
        end else begin
            cyc  = cyc + 1;          // inputs seen now belong to cycle prev
            prev = cyc - 1;
            idle_prev = !active || (ended && prev >= end_cyc + CD);
            ed = req_dog && dog_turn && m_armd;
            ec = req_cat && cat_turn && m_armc;
            grant = idle_prev && (ed || ec);
            own = 0;
            if (grant) begin
                own = (ed && ec) ? !m_last : ec;
                active = 1; ended = 0; g_cyc = cyc; m_own = own;
                m_force = own ? force_cat : force_dog;
                m_dir = own;
                if (own) m_tcat = (m_tcat < 255) ? m_tcat + 1 : 255;
                else     m_tdog = (m_tdog < 255) ? m_tdog + 1 : 255;
            end else if (active && !ended && prev > g_cyc) begin
                if (eng_done) begin
                    ended = 1; end_cyc = cyc; m_hit = eng_hit; m_abort = 0; m_last = m_own;
                end else if (prev - g_cyc == TO) begin
                    ended = 1; end_cyc = cyc; m_hit = 0; m_abort = 1; m_last = m_own;
                    m_tflag = 1;
                    m_tos = (m_tos < 255) ? m_tos + 1 : 255;
                end
            end
            if (grant && !own) m_armd = 0; else if (!req_dog) m_armd = 1;
            if (grant && own)  m_armc = 0; else if (!req_cat) m_armc = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit e_live, e_gnt, e_busy, e_start, e_end;
    always @(negedge clk) begin
        e_live  = active && cyc >= g_cyc;
        e_gnt   = e_live && (!ended || cyc < end_cyc);
        e_busy  = e_live && (!ended || cyc < end_cyc + CD);
        e_start = e_live && cyc == g_cyc;
        e_end   = e_live && ended && cyc == end_cyc;
        check("gnt_dog",   32'(gnt_dog),   32'(e_gnt && !m_own));
        check("gnt_cat",   32'(gnt_cat),   32'(e_gnt && m_own));
        check("eng_start", 32'(eng_start), 32'(e_start));
        check("eng_force", 32'(eng_force), 32'(m_force));
        check("eng_dir",   32'(eng_dir),   32'(m_dir));
        check("eng_abort", 32'(eng_abort), 32'(e_end && m_abort));
        check("done_dog",  32'(done_dog),  32'(e_end && !m_own));
        check("done_cat",  32'(done_cat),  32'(e_end && m_own));
        check("hit_cat",   32'(hit_cat),   32'(e_end && !m_abort && m_hit && !m_own));
        check("hit_dog",   32'(hit_dog),   32'(e_end && !m_abort && m_hit && m_own));
        check("busy",      32'(busy),      32'(e_busy));
        check("timeout_flag", 32'(timeout_flag), 32'(m_tflag));
`ifdef THROW_ARB_STATS_EN
        check("throws_dog", 32'(throws_dog), 32'(m_tdog));
        check("throws_cat", 32'(throws_cat), 32'(m_tcat));
        check("timeouts",   32'(timeouts),   32'(m_tos));
`else
        check("throws_dog", 32'(throws_dog), 32'd0);
        check("throws_cat", 32'(throws_cat), 32'd0);
        check("timeouts",   32'(timeouts),   32'd0);
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_start();
        int n = 0;
        while (!eng_start && n < 300) begin @(negedge clk); n++; end
        check("start_seen", 32'(eng_start), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin @(negedge clk); n++; end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic pulse_done(input logic hit);
        eng_done = 1'b1; eng_hit = hit;
        @(negedge clk);
        eng_done = 1'b0; eng_hit = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    int  n;
    bit  seen;

    initial begin
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // basic dog throw with hit
        dog_turn = 1'b1; req_dog = 1'b1; force_dog = FW'(300);
        @(negedge clk);
        check("t1_gnt_dog", 32'(gnt_dog), 32'd1);
        check("t1_start", 32'(eng_start), 32'd1);
        check("t1_force", 32'(eng_force), 32'd300);
        check("t1_dir", 32'(eng_dir), 32'd0);
        check("t1_model_force", 32'(m_force), 32'd300);
        @(negedge clk);
        check("t1_start_1cyc", 32'(eng_start), 32'd0);
        repeat (3) @(negedge clk);
        pulse_done(1'b1);
        check("t1_done_dog", 32'(done_dog), 32'd1);
        check("t1_hit_cat", 32'(hit_cat), 32'd1);
        check("t1_gnt_off", 32'(gnt_dog), 32'd0);
        n = 0;
        while (busy && n < 1000) begin n++; @(negedge clk); end
        check("t1_cooldown_len", 32'(n), 32'(CD));

        // held request must not re-throw
        seen = 0;
        repeat (CD + 5) begin @(negedge clk); seen |= gnt_dog; end
        check("t2_held_no_regrant", 32'(seen), 32'd0);
        req_dog = 1'b0; @(negedge clk); req_dog = 1'b1;
        wait_start();
        check("t2_regrant", 32'(gnt_dog), 32'd1);
        repeat (2) @(negedge clk);
        pulse_done(1'b0);
        check("t2_done_dog", 32'(done_dog), 32'd1);
        check("t2_no_hit", 32'(hit_cat), 32'd0);
        wait_idle();

        // cat request without cat turn
        dog_turn = 1'b0; req_dog = 1'b0; cat_turn = 1'b0; req_cat = 1'b1;
        seen = 0;
        repeat (10) begin @(negedge clk); seen |= busy | gnt_cat; end
        check("t3_no_turn_no_grant", 32'(seen), 32'd0);

        // tie after reset: dog first, then cat
        dog_turn = 1'b1; cat_turn = 1'b1; req_dog = 1'b1; req_cat = 1'b1;
        force_dog = FW'(111); force_cat = FW'(222);
        do_reset();
        wait_start();
        check("t4_tie_dog", 32'(gnt_dog), 32'd1);
        check("t4_force_dog", 32'(eng_force), 32'd111);
        repeat (2) @(negedge clk);
        pulse_done(1'b0);
        wait_idle();
        wait_start();
        check("t4_rr_cat", 32'(gnt_cat), 32'd1);
        check("t4_dir_cat", 32'(eng_dir), 32'd1);
        check("t4_force_cat", 32'(eng_force), 32'd222);

        // timeout on cat flight
        n = 0;
        while (!eng_abort && n < 300) begin @(negedge clk); n++; end
        check("t5_abort_flight_cycle", 32'(n - 1), 32'(TO));
        check("t5_done_cat", 32'(done_cat), 32'd1);
        check("t5_no_hit", 32'(hit_dog), 32'd0);
        check("t5_tflag", 32'(timeout_flag), 32'd1);
        wait_idle();

        // done on the timeout cycle wins
        req_cat = 1'b0; @(negedge clk); req_cat = 1'b1;
        wait_start();
        check("t5b_gnt_cat", 32'(gnt_cat), 32'd1);
        repeat (TO) @(negedge clk);
        pulse_done(1'b1);
        check("t5b_no_abort", 32'(eng_abort), 32'd0);
        check("t5b_done_cat", 32'(done_cat), 32'd1);
        check("t5b_hit_dog", 32'(hit_dog), 32'd1);
        wait_idle();

        // reset mid flight, then a late done
        req_dog = 1'b0; req_cat = 1'b0; @(negedge clk); req_dog = 1'b1;
        wait_start();
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_gnt", 32'(gnt_dog), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_force", 32'(eng_force), 32'd0);
        check("t6_rst_tflag", 32'(timeout_flag), 32'd0);
        req_dog = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        pulse_done(1'b1);
        check("t6_late_done", 32'(done_dog), 32'd0);
        check("t6_late_hit", 32'(hit_cat), 32'd0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            dog_turn  = ($urandom_range(0, 7) != 0);
            cat_turn  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) req_dog = ~req_dog;
            if ($urandom_range(0, 3) == 0) req_cat = ~req_cat;
            force_dog = FW'($urandom);
            force_cat = FW'($urandom);
            eng_done  = ($urandom_range(0, 39) == 0);
            eng_hit   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1499) == 0) do_reset();
        end
        eng_done = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
